// File: rtl/capture_reg_arbiter_pkg.sv
// Shared definitions for the capture register arbiter: FSM states, default
// data width and the source-index width helper.
package capture_reg_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/capture_reg_arbiter_if.sv
// Requester-side and readout-side handshake bundle of the capture register arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface capture_reg_arbiter_if
    import capture_reg_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = 4
);
    localparam int SRC_W = src_w(NUM_REQ);

    logic [NUM_REQ-1:0]            req_vld;
    logic [NUM_REQ-1:0]            req_rdy;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_vld;
    logic [SRC_W-1:0]              out_src;
    logic                          out_rdy;

    modport master (
        output req_vld, req_data, out_rdy,
        input  req_rdy, out_data, out_vld, out_src
    );

    modport slave (
        input  req_vld, req_data, out_rdy,
        output req_rdy, out_data, out_vld, out_src
    );

endinterface

// File: rtl/capture_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from NUM_REQ-1 back to 0.
module capture_reg_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SRC_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int               pos;
        logic [SRC_W-1:0] pos_idx;
        gnt     = '0;
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos     = (int'(ptr) + k) % NUM_REQ;
            pos_idx = SRC_W'(pos);
            if (!any && req[pos_idx]) begin
                any          = 1'b1;
                idx          = pos_idx;
                gnt[pos_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/capture_reg_arbiter.sv
// Shares one capture register among NUM_REQ sources with round-robin arbitration.
// Optional per-requester grant counters: define CAPTURE_ARB_GRANT_CNT_EN.
module capture_reg_arbiter
    import capture_reg_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     arb_en,
    capture_reg_arbiter_if.slave     bus
`ifdef CAPTURE_ARB_GRANT_CNT_EN
    ,
    input  logic                     cnt_clr,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);

    localparam int SRC_W = src_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("capture_reg_arbiter: NUM_REQ must be within 2..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("capture_reg_arbiter: CNT_W must be at least 1");
    end

    state_t                state;
    state_t                next_state;
    logic [SRC_W-1:0]      rr_ptr;
    logic [DATA_WIDTH-1:0] data_q;
    logic [SRC_W-1:0]      src_q;

    logic [NUM_REQ-1:0]    gnt;
    logic [SRC_W-1:0]      gnt_idx;
    logic                  any_req;
    logic                  can_load;
    logic                  accept;
    logic [DATA_WIDTH-1:0] win_word;

    capture_reg_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_rr_pick (
        .req (bus.req_vld),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (any_req)
    );

    assign win_word = bus.req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

    // A full register can be refilled in the same cycle it drains, giving one word per cycle.
    always_comb begin
        can_load   = arb_en & ((state == IDLE) | bus.out_rdy);
        accept     = can_load & any_req;
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = FULL;
            FULL:    if (!accept && bus.out_rdy) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign bus.req_rdy  = can_load ? gnt : '0;
    assign bus.out_vld  = (state == FULL);
    assign bus.out_data = data_q;
    assign bus.out_src  = src_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            data_q <= '0;
            src_q  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                data_q <= win_word;
                src_q  <= gnt_idx;
                rr_ptr <= (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
            end
        end
    end

`ifdef CAPTURE_ARB_GRANT_CNT_EN
    // Saturating counters; a clear overrides an increment in the same cycle.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge clk) begin
            if (!rstn || cnt_clr) begin
                cnt_q <= '0;
            end else if (accept && gnt_idx == SRC_W'(i) && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_capture_reg_arbiter.sv
// Directed self-checking bench for capture_reg_arbiter; the counter section
// runs only when CAPTURE_ARB_GRANT_CNT_EN is defined.
module tb_capture_reg_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int CW = 4;

    logic clk    = 1'b0;
    logic rstn   = 1'b0;
    logic arb_en = 1'b0;
    int   num_checks = 0;
    int   num_fails  = 0;
    logic [NR-1:0] pending = '0;
`ifdef CAPTURE_ARB_GRANT_CNT_EN
    logic             cnt_clr = 1'b0;
    logic [NR*CW-1:0] grant_cnt;
`endif

    capture_reg_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    capture_reg_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .arb_en    (arb_en),
        .bus       (bus)
`ifdef CAPTURE_ARB_GRANT_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic vld, input int src, input logic [31:0] data);
        check_output({tag, "_vld"}, 64'(bus.out_vld), 64'(vld));
        check_output({tag, "_src"}, 64'(bus.out_src), 64'(src));
        check_output({tag, "_data"}, 64'(bus.out_data), 64'(data));
    endtask

    task automatic apply_stimulus(input logic [NR-1:0] vld, input logic rdy, input logic en);
        bus.req_vld = vld;
        bus.out_rdy = rdy;
        arb_en      = en;
        #1;
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        bus.req_data[i*DW +: DW] = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // A requester with a pending word must keep its valid up until it is accepted.
    always @(negedge clk) begin
        if (rstn && arb_en && pending != '0)
            check_output("vld_hold", 64'(bus.req_vld & pending), 64'(pending));
        pending = (rstn && arb_en) ? (bus.req_vld & ~bus.req_rdy) : '0;
    end

    initial begin
        for (int i = 0; i < NR; i++) set_word(i, 32'hA000_0000 + 32'(i));
        apply_stimulus(4'b1111, 1'b0, 1'b0);

        // Reset with every requester valid
        repeat (3) tick();
        check_regs("t1_reset", 1'b0, 0, 32'h0);
        check_output("t1_rdy", 64'(bus.req_rdy), 64'h0);

        // All requesters valid: strict rotation at one word per cycle
        rstn = 1'b1;
        apply_stimulus(4'b1111, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            automatic int g = k % NR;
            check_output("t2_rdy", 64'(bus.req_rdy), 64'd1 << g);
            tick();
            check_regs("t2_word", 1'b1, g, 32'hA000_0000 + 32'(g));
        end
        apply_stimulus(4'b1111, 1'b1, 1'b0);
        check_output("t2_off_rdy", 64'(bus.req_rdy), 64'h0);
        tick();
        check_output("t2_drain_vld", 64'(bus.out_vld), 64'h0);

        // Backpressure on requester 2
        set_word(2, 32'hDEAD_BEEF);
        apply_stimulus(4'b0100, 1'b0, 1'b1);
        check_output("t3_rdy", 64'(bus.req_rdy), 64'h4);
        tick();
        check_regs("t3_load", 1'b1, 2, 32'hDEAD_BEEF);
        for (int k = 0; k < 5; k++) begin
            check_output("t3_hold_rdy", 64'(bus.req_rdy), 64'h0);
            tick();
            check_regs("t3_hold", 1'b1, 2, 32'hDEAD_BEEF);
        end
        apply_stimulus(4'b0100, 1'b1, 1'b1);
        check_output("t3_reload_rdy", 64'(bus.req_rdy), 64'h4);
        tick();
        check_regs("t3_reload", 1'b1, 2, 32'hDEAD_BEEF);
        apply_stimulus(4'b0000, 1'b1, 1'b1);
        check_output("t3_empty_rdy", 64'(bus.req_rdy), 64'h0);
        tick();
        check_output("t3_drain_vld", 64'(bus.out_vld), 64'h0);

        // Wrap from pointer 3 back to 0, then pointer lands on 1
        apply_stimulus(4'b1001, 1'b1, 1'b1);
        check_output("t4_rdy3", 64'(bus.req_rdy), 64'h8);
        tick();
        check_regs("t4_g3", 1'b1, 3, 32'hA000_0003);
        check_output("t4_rdy0", 64'(bus.req_rdy), 64'h1);
        tick();
        check_regs("t4_g0", 1'b1, 0, 32'hA000_0000);
        apply_stimulus(4'b1111, 1'b1, 1'b1);
        check_output("t4_ptr1", 64'(bus.req_rdy), 64'h2);
        tick();
        check_regs("t4_g1", 1'b1, 1, 32'hA000_0001);

        // Arbitration disabled while full: hold, drain, no new grant, then resume
        apply_stimulus(4'b1111, 1'b0, 1'b0);
        check_output("t5_off_rdy", 64'(bus.req_rdy), 64'h0);
        tick();
        check_regs("t5_hold", 1'b1, 1, 32'hA000_0001);
        apply_stimulus(4'b1111, 1'b1, 1'b0);
        check_output("t5_drain_rdy", 64'(bus.req_rdy), 64'h0);
        tick();
        check_output("t5_drain_vld", 64'(bus.out_vld), 64'h0);
        tick();
        check_output("t5_nogrant_vld", 64'(bus.out_vld), 64'h0);
        apply_stimulus(4'b1111, 1'b1, 1'b1);
        check_output("t5_resume_rdy", 64'(bus.req_rdy), 64'h4);
        tick();
        check_regs("t5_resume", 1'b1, 2, 32'hDEAD_BEEF);

        // Reset pulse while full discards the word and clears the pointer
        rstn = 1'b0;
        apply_stimulus(4'b1111, 1'b0, 1'b0);
        tick();
        check_regs("t5_rst", 1'b0, 0, 32'h0);
        rstn = 1'b1;
        apply_stimulus(4'b1100, 1'b1, 1'b1);
        check_output("t5_rst_ptr", 64'(bus.req_rdy), 64'h4);
        tick();
        check_regs("t5_post2", 1'b1, 2, 32'hDEAD_BEEF);
        apply_stimulus(4'b1000, 1'b1, 1'b1);
        check_output("t5_rdy3", 64'(bus.req_rdy), 64'h8);
        tick();
        check_regs("t5_post3", 1'b1, 3, 32'hA000_0003);
        apply_stimulus(4'b0000, 1'b1, 1'b1);
        tick();
        check_output("t5_idle_vld", 64'(bus.out_vld), 64'h0);

`ifdef CAPTURE_ARB_GRANT_CNT_EN
        // Saturating grant counter on requester 1 and clear priority
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check_output("t6_clr0", 64'(grant_cnt), 64'h0);
        apply_stimulus(4'b0010, 1'b1, 1'b1);
        repeat (5) tick();
        check_output("t6_cnt5", 64'(grant_cnt[7:4]), 64'd5);
        repeat (15) tick();
        check_output("t6_cnt_sat", 64'(grant_cnt[7:4]), 64'd15);
        check_output("t6_other", 64'({grant_cnt[15:8], grant_cnt[3:0]}), 64'h0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check_output("t6_clr_wins", 64'(grant_cnt[7:4]), 64'd0);
        apply_stimulus(4'b0000, 1'b1, 1'b1);
        tick();
        check_output("t6_cleared", 64'(grant_cnt), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
